// File: rtl/csr_access_unit.sv
`timescale 1ns/1ps
// csr_access_unit: sequences Zicsr read-modify-write accesses against the CSR file.
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   start, funct3, csrAddress,     request strobe and operands, captured in IDLE
//   rs1Index, rs1Value, rdIndex
//   busy, done, illegal            status; illegal is valid with done
//   rdWriteEnable/Index/Data       rd writeback of the old CSR value, valid with done
//   csrRead*                       read strobe, address and returned data
//   csrWrite*                      write strobe, address and data
// Build option: define CSR_ACCESS_READONLY_CHECK_EN to flag writes to read-only CSRs
// (csrAddress[11:10]==2'b11) as illegal instead of issuing the write strobe.
module csr_access_unit #(
   parameter int CSR_READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [11:0] csrAddress,
   input  logic [4:0]  rs1Index,
   input  logic [31:0] rs1Value,
   input  logic [4:0]  rdIndex,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        rdWriteEnable,
   output logic [4:0]  rdWriteIndex,
   output logic [31:0] rdWriteData,
   output logic        csrReadEnable,
   output logic [11:0] csrReadAddress,
   input  logic [31:0] csrReadData,
   output logic        csrWriteEnable,
   output logic [11:0] csrWriteAddress,
   output logic [31:0] csrWriteData
);
   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
   state_t state, state_next;
   logic [2:0] f3;
   logic [11:0] addr;
   logic [4:0] idx, rd;
   logic [31:0] val, old_value, src, wdata;
   logic [1:0] cnt;
   logic in_bad, in_dr, in_dw, in_ill, bad, dr, dw, ill, last_wait;
   // {bad funct3, read intent, write intent}; RS/RC write intent follows the index/zimm, not the value
   function automatic logic [2:0] decode(input logic [2:0] f, input logic [4:0] i, input logic [4:0] r);
      logic rw;
      rw = f[1:0] == 2'b01;
      return {f[1:0] == 2'b00, !(rw && r == 5'd0), rw || i != 5'd0};
   endfunction
   assign {in_bad, in_dr, in_dw} = decode(funct3, rs1Index, rdIndex);
   assign {bad, dr, dw} = decode(f3, idx, rd);
`ifdef CSR_ACCESS_READONLY_CHECK_EN
   assign in_ill = in_bad || (csrAddress[11:10] == 2'b11 && in_dw);
   assign ill = bad || (addr[11:10] == 2'b11 && dw);
`else
   assign in_ill = in_bad;
   assign ill = bad;
`endif
   assign last_wait = cnt == 2'(CSR_READ_LATENCY - 1);
   assign src = f3[2] ? {27'b0, idx} : val;
   assign wdata = f3[1:0] == 2'b01 ? src : f3[1:0] == 2'b10 ? (old_value | src) : (old_value & ~src);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         f3 <= '0;
         addr <= '0;
         idx <= '0;
         val <= '0;
         rd <= '0;
         old_value <= '0;
         cnt <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            f3 <= funct3;
            addr <= csrAddress;
            idx <= rs1Index;
            val <= rs1Value;
            rd <= rdIndex;
            old_value <= '0;
            cnt <= '0;
         end
         if (state == WAIT) begin
            cnt <= cnt + 2'd1;
            if (last_wait) old_value <= csrReadData;
         end
      end
   end
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start) state_next = in_ill ? DONE : in_dr ? READ : WRITE;
         READ:  state_next = WAIT;
         WAIT:  if (last_wait) state_next = dw ? WRITE : DONE;
         WRITE: state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign illegal = done && ill;
   assign rdWriteEnable = done && dr && rd != 5'd0 && !ill;
   assign rdWriteIndex = done ? rd : 5'd0;
   assign rdWriteData = done ? old_value : 32'd0;
   assign csrReadEnable = state == READ;
   assign csrReadAddress = csrReadEnable ? addr : 12'd0;
   assign csrWriteEnable = state == WRITE;
   assign csrWriteAddress = csrWriteEnable ? addr : 12'd0;
   assign csrWriteData = csrWriteEnable ? wdata : 32'd0;
endmodule

// File: tb/tb_csr_access_unit.sv
`timescale 1ns/1ps
// tb_csr_access_unit: directed and randomized Zicsr accesses against a CSR-file model.
module tb_csr_access_unit;
   logic clk, rst, start;
   logic [2:0] funct3;
   logic [11:0] csrAddress;
   logic [4:0] rs1Index, rdIndex;
   logic [31:0] rs1Value;
   logic busy, done, illegal, rdWriteEnable;
   logic [4:0] rdWriteIndex;
   logic [31:0] rdWriteData;
   logic csrReadEnable, csrWriteEnable;
   logic [11:0] csrReadAddress, csrWriteAddress;
   logic [31:0] csrReadData, csrWriteData;
   logic [31:0] mem [0:4095];
   int checks = 0;
   int errors = 0;
   csr_access_unit dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .csrAddress(csrAddress),
      .rs1Index(rs1Index), .rs1Value(rs1Value), .rdIndex(rdIndex), .busy(busy), .done(done),
      .illegal(illegal), .rdWriteEnable(rdWriteEnable), .rdWriteIndex(rdWriteIndex),
      .rdWriteData(rdWriteData), .csrReadEnable(csrReadEnable), .csrReadAddress(csrReadAddress),
      .csrReadData(csrReadData), .csrWriteEnable(csrWriteEnable), .csrWriteAddress(csrWriteAddress),
      .csrWriteData(csrWriteData)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_flags"}, {illegal, rdWriteEnable, csrReadEnable, csrWriteEnable}, 0);
      chk({tag, "_addr"}, {csrReadAddress, csrWriteAddress}, 0);
      chk({tag, "_wdata"}, csrWriteData, 0);
      chk({tag, "_rdata"}, rdWriteData, 0);
      chk({tag, "_rdidx"}, rdWriteIndex, 0);
   endtask
   // Called at a negedge with the DUT idle; returns at the negedge after done.
   task automatic run_op(input logic [2:0] f, input logic [11:0] a, input logic [4:0] i,
                         input logic [31:0] v, input logic [4:0] r, input bit poke);
      logic rw, dr, dw, ill, we_exp;
      logic [31:0] src, old, nv;
      int lat, n, nr, nw;
      bit seen;
      rw = f[1:0] == 2'b01;
      src = f[2] ? {27'b0, i} : v;
      dr = !(rw && r == 0);
      dw = rw || i != 0;
      ill = f[1:0] == 2'b00;
`ifdef CSR_ACCESS_READONLY_CHECK_EN
      ill = ill || (a[11:10] == 2'b11 && dw);
`endif
      old = mem[a];
      nv = rw ? src : (f[1:0] == 2'b10) ? (old | src) : (old & ~src);
      lat = ill ? 1 : (dr && dw) ? 4 : dr ? 3 : 2;
      we_exp = dr && r != 0 && !ill;
      funct3 = f; csrAddress = a; rs1Index = i; rs1Value = v; rdIndex = r;
      start = 1;
      csrReadData = $urandom;
      @(negedge clk);
      start = 0;
      funct3 = 3'($urandom); csrAddress = 12'($urandom); rs1Index = 5'($urandom);
      rs1Value = $urandom; rdIndex = 5'($urandom);
      n = 1; nr = 0; nw = 0; seen = 0;
      while (!seen && n <= 12) begin
         chk("busy", busy, 1);
         if (csrReadEnable) begin
            nr++;
            chk("rd_addr", csrReadAddress, a);
            csrReadData = mem[a];
         end else chk("rd_addr_idle", csrReadAddress, 0);
         if (csrWriteEnable) begin
            nw++;
            chk("wr_addr", csrWriteAddress, a);
            chk("wr_data", csrWriteData, nv);
            mem[a] = csrWriteData;
         end else chk("wr_idle", {csrWriteAddress, csrWriteData}, 0);
         if (poke) start = n == 1;
         if (done) begin
            seen = 1;
            chk("latency", n, lat);
            chk("illegal", illegal, ill);
            chk("rd_we", rdWriteEnable, we_exp);
            if (we_exp) begin
               chk("rd_idx", rdWriteIndex, r);
               chk("rd_data", rdWriteData, old);
            end
         end else begin
            n++;
            @(negedge clk);
         end
      end
      start = 0;
      chk("timeout", seen, 1);
      chk("n_reads", nr, dr && !ill);
      chk("n_writes", nw, dw && !ill);
      @(negedge clk);
      chk("after_busy", busy, 0);
      chk("after_done", done, 0);
   endtask
   initial begin
      logic [11:0] addrs [6];
      logic [11:0] a;
      addrs = '{12'h340, 12'h300, 12'hC00, 12'hF11, 12'h7C0, 12'h305};
      for (int k = 0; k < 4096; k++) mem[k] = $urandom;
      rst = 0; start = 0; funct3 = 0; csrAddress = 0; rs1Index = 0; rs1Value = 0; rdIndex = 0;
      csrReadData = 0;
      #1 chk_quiet("reset");
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk_quiet("idle");
      mem[12'h340] = 32'h12345678;
      run_op(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 5'd5, 0);
      chk("csrrw_mem", mem[12'h340], 32'hDEADBEEF);
      run_op(3'b010, 12'hC00, 5'd0, 32'hFFFFFFFF, 5'd3, 0);
      mem[12'h300] = 32'h0000000F;
      run_op(3'b111, 12'h300, 5'd8, 32'h0, 5'd4, 0);
      chk("csrrci_mem", mem[12'h300], 32'h00000007);
      run_op(3'b101, 12'h340, 5'd31, 32'h0, 5'd0, 0);
      chk("csrrwi_mem", mem[12'h340], 32'h0000001F);
      run_op(3'b001, 12'hF11, 5'd1, 32'hA5A5A5A5, 5'd2, 0);
      run_op(3'b100, 12'h340, 5'd6, 32'h1, 5'd7, 0);
      run_op(3'b000, 12'h300, 5'd6, 32'h1, 5'd7, 0);
      run_op(3'b011, 12'h305, 5'd2, 32'hF0F0F0F0, 5'd9, 1);
      run_op(3'b110, 12'h7C0, 5'd0, 32'h0, 5'd0, 1);
      // reset during WAIT: outputs drop at once and the operation never completes
      mem[12'h305] = 32'h13579BDF;
      funct3 = 3'b001; csrAddress = 12'h305; rs1Index = 5'd3; rs1Value = 32'h2468ACE0; rdIndex = 5'd7;
      start = 1;
      @(negedge clk);
      start = 0;
      chk("pre_rst_read", csrReadEnable, 1);
      csrReadData = mem[12'h305];
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #2 rst = 0;
      #1 chk_quiet("async_rst");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_no_done", {done, csrWriteEnable}, 0);
      end
      rst = 1;
      @(negedge clk);
      chk_quiet("post_rst");
      chk("rst_mem", mem[12'h305], 32'h13579BDF);
      for (int k = 0; k < 40; k++) begin
         a = $urandom_range(0, 6) == 6 ? 12'($urandom) : addrs[$urandom_range(0, 5)];
         run_op(3'($urandom), a, $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom), $urandom,
                $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom), 1'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Core-side initiator for the CSR read/write interface; the CSR file is the responder.
- Executes Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) as a sequenced read-modify-write.
- Issues csrRead*/csrWrite* strobes, returns the old CSR value for the rd writeback, and flags illegal accesses to the trap logic.
- Sits between the decode/execute stage and the CSR file.

Parameters:
- CSR_READ_LATENCY, 1, cycles from a csrReadEnable cycle to csrReadData being valid. Supported values: 1 or 2.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request strobe; sampled in IDLE only
- funct3  input  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- csrAddress  input  12  target CSR
- rs1Index  input  5  rs1 index; doubles as zimm for the immediate forms
- rs1Value  input  32  rs1 register value
- rdIndex  input  5  destination register
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- illegal  output  1  valid with done; the access was illegal
- rdWriteEnable  output  1  valid with done; write rdWriteData to rdWriteIndex
- rdWriteIndex  output  5  captured rdIndex
- rdWriteData  output  32  old CSR value
- csrReadEnable  output  1  read strobe to the CSR file
- csrReadAddress  output  12  read address
- csrReadData  input  32  read data from the CSR file
- csrWriteEnable  output  1  write strobe to the CSR file
- csrWriteAddress  output  12  write address
- csrWriteData  output  32  write data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including busy, done, illegal, rdWriteEnable and both enables.
  - All captured registers 0.
  - Reset mid-operation aborts immediately: no further strobes, no done.
- Capture on start: funct3, csrAddress, rs1Index, rs1Value and rdIndex are registered when start=1 in IDLE.
  - start while busy is ignored; the request is not queued.
- Source operand: src = funct3[2] ? {27'b0, rs1Index} : rs1Value.
- Flags:
  - doRead = !(RW-type && rdIndex==0)
  - doWrite = RW-type || rs1Index!=0
  - For RS/RC, doWrite depends on the index/zimm, not on the rs1 value.
- Illegal when any of the following holds:
  - funct3 is 000 or 100.
  - A write to a read-only CSR (csrAddress[11:10]==2'b11 && doWrite); subject to the optional feature.
- States:
  - IDLE -> DONE if illegal; -> READ if doRead; otherwise -> WRITE.
  - READ: csrReadEnable=1 and csrReadAddress=addr for exactly one cycle. Then -> WAIT.
  - WAIT: held CSR_READ_LATENCY cycles. csrReadData is captured into oldValue on the final WAIT edge. Then -> WRITE if doWrite, else -> DONE.
  - WRITE: csrWriteEnable=1 for one cycle.
    - csrWriteAddress=addr.
    - csrWriteData = RW: src; RS: oldValue|src; RC: oldValue&~src.
    - Then -> DONE.
  - DONE:
    - done=1 and illegal as computed.
    - rdWriteEnable = doRead && rdIndex!=0 && !illegal.
    - rdWriteData=oldValue.
    - Then -> IDLE.
- csrReadAddress, csrWriteAddress and csrWriteData are 0 whenever their enable is low.
- Read and write enables are never high in the same cycle.
- Latency, from the start edge to the done cycle, at CSR_READ_LATENCY=1:
  - read+write: 4 cycles (READ, WAIT, WRITE, DONE)
  - read only: 3 cycles
  - write only: 2 cycles
  - illegal: 1 cycle
- A new start is accepted on the cycle after done.
- Back-to-back throughput: one operation per (latency+1) cycles.

Optional Feature:
- Macro CSR_ACCESS_READONLY_CHECK_EN.
- Defined: a write intent to csrAddress[11:10]==2'b11 is illegal. No csrWriteEnable is issued, rdWriteEnable=0, and illegal=1 with done.
- Undefined: the only illegal condition is a bad funct3. The write strobe is issued, and the responder is trusted to ignore it.

Test Plan:
- CSRRW, addr 0x340, rs1Value=0xDEADBEEF, rd=5, CSR holding 0x12345678 -> read strobe, then write strobe with 0xDEADBEEF; done at start+4 with rdWriteEnable=1, rdWriteIndex=5, rdWriteData=0x12345678.
- CSRRS, addr 0xC00, rs1Index=0, rd=3 -> read only, no csrWriteEnable; done at start+3 with rdWriteData equal to the sampled csrReadData.
- CSRRCI, addr 0x300, zimm=0x08, old value 0x0000000F -> csrWriteData=0x00000007.
- CSRRWI, addr 0x340, rd=0, zimm=0x1F -> no csrReadEnable; csrWriteData=0x0000001F; done at start+2 with rdWriteEnable=0.
- CSRRW to 0xF11, rs1Index=1, with the macro defined -> done+illegal at start+1, no strobes. funct3=100 -> illegal regardless of the macro.
- Assert rst=0 during WAIT -> all outputs 0 asynchronously, no done. A second start pulsed during busy is ignored: exactly one done and one write.
